// File: rtl/aoi_exerciser_if.sv
// Pin-side bundle between the AOI exerciser and the gate under test plus its status outputs.
// master = board/controller side, slave = exerciser.
interface aoi_exerciser_if;
    logic       start;
    logic       f_in;
    logic [3:0] abcd;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] err_cnt;
    logic [3:0] first_err_vec;

    modport master (
        output start, f_in,
        input  abcd, busy, done, fail, err_cnt, first_err_vec
    );

    modport slave (
        input  start, f_in,
        output abcd, busy, done, fail, err_cnt, first_err_vec
    );
endinterface

// File: rtl/aoi_exerciser.sv
// Sweeps all 16 AOI input vectors, samples F after a settle time and counts mismatches.
// Optional AOI_EXERCISER_STOP_ON_ERR_EN: the first mismatch ends the run.
//
// state  | meaning
// IDLE   | waiting for start; results of last run held
// SETTLE | vector driven, waiting SETTLE_CYCLES cycles
// SAMPLE | f_in compared on the edge leaving this state
// DONE   | one-cycle end-of-run pulse, abcd parked at 0
module aoi_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    aoi_exerciser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic [3:0] pass_q, pass_d;
    logic [3:0] abcd_q, abcd_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       fail_q, fail_d;
    logic [3:0] first_err_q, first_err_d;

    logic exp_f;
    logic mismatch;
    logic last_vec;
    logic stop_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            pass_q       <= '0;
            abcd_q       <= '0;
            err_cnt_q    <= '0;
            fail_q       <= 1'b0;
            first_err_q  <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            pass_q       <= pass_d;
            abcd_q       <= abcd_d;
            err_cnt_q    <= err_cnt_d;
            fail_q       <= fail_d;
            first_err_q  <= first_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        pass_d       = pass_q;
        abcd_d       = abcd_q;
        err_cnt_d    = err_cnt_q;
        fail_d       = fail_q;
        first_err_d  = first_err_q;

        exp_f    = ~((abcd_q[3] & abcd_q[2]) | (abcd_q[1] & abcd_q[0]));
        mismatch = (bus.f_in != exp_f);
        last_vec = (abcd_q == 4'hF) && (pass_q == 4'(PASSES - 1));
`ifdef AOI_EXERCISER_STOP_ON_ERR_EN
        stop_run = last_vec | mismatch;
`else
        stop_run = last_vec;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                    pass_d       = '0;
                    abcd_d       = '0;
                    err_cnt_d    = '0;
                    fail_d       = 1'b0;
                    first_err_d  = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                settle_cnt_d = '0;
                if (mismatch) begin
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    fail_d = 1'b1;
                    if (!fail_q) first_err_d = abcd_q;
                end
                if (stop_run) begin
                    state_d = DONE;
                    abcd_d  = '0;
                end else begin
                    state_d = SETTLE;
                    abcd_d  = abcd_q + 4'd1;
                    if (abcd_q == 4'hF) pass_d = pass_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status is decoded from registered state so every output clears with the async reset.
    assign bus.abcd          = abcd_q;
    assign bus.busy          = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done          = (state_q == DONE);
    assign bus.fail          = fail_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_vec = first_err_q;
endmodule
